// File: rtl/rv32im_mdu_seq.sv
// Iterative RV32M/RV64M multiply/divide unit with a valid/ready request and result handshake.
// Latency: special-case divides and (with MDU_FAST_MUL_EN) multiplies give valid_o on the accept edge; other ops after XLEN more edges.
// Backpressure: result is held in DONE until ready_i; ready_o is low until the unit is back in IDLE.
//
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle multiplier for MUL/MULH/MULHSU/MULHU).
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   valid_i / ready_o       request handshake; op_i, rs1_i, rs2_i sampled only on acceptance
//   flush_i                 abort any operation, return to IDLE next edge (highest priority)
//   valid_o / ready_i       result handshake; result_o held stable while valid_o && !ready_i
//   busy_o                  high while an operation is in flight or its result is pending
module rv32im_mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [2:0]        op_q;
  logic              neg_a_q;    // dividend/multiplicand was negative
  logic              neg_res_q;  // quotient/product must be negated at the end
  logic [2*XLEN-1:0] acc_q;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opb_q;      // |multiplicand| for mul, |divisor| for div
  logic [CNT_W-1:0]  cnt_q;

  // The reset term keeps ready_o low as soon as rst_i rises, not one edge later.
  assign ready_o = (state_q == IDLE) && !rst_i;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful on the acceptance edge)
  // ---------------------------------------------------------------------------
  logic            sgn_a_in, sgn_b_in;
  logic            neg_a_in, neg_b_in;
  logic [XLEN-1:0] abs_a_in, abs_b_in;
  logic            div_zero_in, div_ovf_in, div_special_in;
  logic [XLEN-1:0] special_res_in;

  always_comb begin
    sgn_a_in = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    // MULHSU deliberately treats rs2 as unsigned.
    sgn_b_in = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    neg_a_in = sgn_a_in && rs1_i[XLEN-1];
    neg_b_in = sgn_b_in && rs2_i[XLEN-1];
    // -INT_MIN wraps back to INT_MIN, which is still the right magnitude read as unsigned.
    abs_a_in = neg_a_in ? (~rs1_i + 1'b1) : rs1_i;
    abs_b_in = neg_b_in ? (~rs2_i + 1'b1) : rs2_i;

    div_zero_in    = (rs2_i == '0);
    div_ovf_in     = (op_i == OP_DIV || op_i == OP_REM) && (rs1_i == INT_MIN) && (rs2_i == '1);
    div_special_in = op_i[2] && (div_zero_in || div_ovf_in);

    // op_i[1] selects REM/REMU within the divide group.
    if (div_zero_in) begin
      special_res_in = op_i[1] ? rs1_i : '1;
    end else begin
      special_res_in = op_i[1] ? '0 : rs1_i;
    end
  end

`ifdef MDU_FAST_MUL_EN
  // Operands are sign/zero extended to 2*XLEN so the truncated product is exact
  // for every mix of signedness.
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_p;
  logic        [XLEN-1:0]   fast_res;

  always_comb begin
    fast_a   = {{XLEN{neg_a_in}}, rs1_i};
    fast_b   = {{XLEN{neg_b_in}}, rs2_i};
    fast_p   = fast_a * fast_b;
    fast_res = (op_i == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  end
`endif

  // ---------------------------------------------------------------------------
  // One iteration of each datapath, plus the sign fix-up applied on the last one
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_diff;
  logic              q_bit;
  logic [XLEN-1:0]   rem_nxt;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    // Shift-add: add multiplicand into the high half when the current multiplier
    // bit is set, then shift the whole accumulator right, carry included.
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring division: shift the next dividend bit into the remainder and
    // keep the subtraction only when it does not borrow.
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    q_bit    = !rem_diff[XLEN];
    rem_nxt  = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    div_nxt  = {rem_nxt, acc_q[XLEN-2:0], q_bit};

    acc_nxt = op_q[2] ? div_nxt : mul_nxt;

    prod_fix = neg_res_q ? (~mul_nxt + 1'b1) : mul_nxt;
    quo      = div_nxt[XLEN-1:0];
    rem      = div_nxt[2*XLEN-1:XLEN];

    final_res = '0;
    case (op_q)
      OP_MUL:                       final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV:                       final_res = neg_res_q ? (~quo + 1'b1) : quo;
      OP_DIVU:                      final_res = quo;
      OP_REM:                       final_res = neg_a_q ? (~rem + 1'b1) : rem;
      OP_REMU:                      final_res = rem;
      default:                      final_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM and all registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_a_q   <= 1'b0;
      neg_res_q <= 1'b0;
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      result_o  <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
    end else if (flush_i) begin
      // Abort wins over accept and over the result handshake; result_o keeps its value.
      state_q <= IDLE;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            op_q      <= op_i;
            neg_a_q   <= neg_a_in;
            neg_res_q <= neg_a_in ^ neg_b_in;
            acc_q     <= {{XLEN{1'b0}}, abs_a_in};
            opb_q     <= abs_b_in;
            cnt_q     <= CNT_W'(XLEN);
            busy_o    <= 1'b1;
            if (div_special_in) begin
              result_o <= special_res_in;
              valid_o  <= 1'b1;
              state_q  <= DONE;
`ifdef MDU_FAST_MUL_EN
            end else if (!op_i[2]) begin
              result_o <= fast_res;
              valid_o  <= 1'b1;
              state_q  <= DONE;
`endif
            end else begin
              state_q <= CALC;
            end
          end
        end

        CALC: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            result_o <= final_res;
            valid_o  <= 1'b1;
            state_q  <= DONE;
          end
        end

        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
